// File: rtl/cdm_pipe_param.sv
// cdm_pipe_param: three-stage pipelined carry-disregard approximate multiplier.
// B is split into two halves. Each half forms a partial product in which the lowest K
// columns keep only their XOR (parity) bit and the upper columns are summed exactly.
// The two partial products are then added exactly.
module cdm_pipe_param #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned K_LO  = 9,
    parameter int unsigned K_HI  = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic               in_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_r,
    output logic               out_mode
);

    localparam int unsigned H  = WIDTH / 2;
    localparam int unsigned PW = WIDTH + H;
    localparam int unsigned RW = 2 * WIDTH;

    // Half partial product. Columns below k keep only their parity bit; columns at or
    // above k are summed exactly. The exact part only produces multiples of 2^k, so it
    // never overlaps the parity bits and the two parts can simply be OR-ed together.
    function automatic logic [PW-1:0] half_prod(input logic [WIDTH-1:0] a,
                                                input logic [H-1:0]     bh,
                                                input int unsigned      k);
        logic [PW-1:0] xr;
        logic [PW-1:0] ex;
        xr = '0;
        ex = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            for (int unsigned j = 0; j < H; j++) begin
                if (a[i] && bh[j]) begin
                    if ((i + j) < k) xr[i+j] = ~xr[i+j];
                    else             ex = ex + (PW'(1) << (i + j));
                end
            end
        end
        return xr | ex;
    endfunction

    logic             v1, v2;
    logic [WIDTH-1:0] a1, b1;
    logic             m1, m2;
    logic [PW-1:0]    plo2, phi2;
    logic             en1, en2, en3;
    logic [PW-1:0]    plo_c, phi_c;
    logic [RW-1:0]    sum_c;

    // Stage enables: a stage loads when it is empty or the stage after it moves.
    always_comb begin
        en3      = !out_valid || out_ready;
        en2      = !v2 || en3;
        en1      = !v1 || en2;
        in_ready = en1;
    end

    // Partial products from stage-1 operands and the exact final addition.
    always_comb begin
        plo_c = half_prod(a1, b1[H-1:0],     m1 ? K_LO : 32'd0);
        phi_c = half_prod(a1, b1[WIDTH-1:H], m1 ? K_HI : 32'd0);
        sum_c = RW'(plo2) + (RW'(phi2) << H);
    end

    // Stage 1: operand capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            a1 <= '0;
            b1 <= '0;
            m1 <= 1'b0;
        end else if (en1) begin
            v1 <= in_valid;
            if (in_valid) begin
                a1 <= in_a;
                b1 <= in_b;
                m1 <= in_mode;
            end
        end
    end

    // Stage 2: half partial products.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2   <= 1'b0;
            plo2 <= '0;
            phi2 <= '0;
            m2   <= 1'b0;
        end else if (en2) begin
            v2 <= v1;
            if (v1) begin
                plo2 <= plo_c;
                phi2 <= phi_c;
                m2   <= m1;
            end
        end
    end

    // Stage 3: final sum, held while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_r     <= '0;
            out_mode  <= 1'b0;
        end else if (en3) begin
            out_valid <= v2;
            if (v2) begin
                out_r    <= sum_c;
                out_mode <= m2;
            end
        end
    end

endmodule

// File: tb/tb_cdm_pipe_param.sv
// Bench for cdm_pipe_param: directed vectors, stall/drain, sparse and random streams,
// and mid-stream reset, all scored against a column-count model of the multiplier.
module tb_cdm_pipe_param;

    localparam int unsigned W    = 8;
    localparam int unsigned H    = W / 2;
    localparam int unsigned K_LO = 9;
    localparam int unsigned K_HI = 5;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_a;
    logic [W-1:0]   in_b;
    logic           in_mode;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] out_r;
    logic           out_mode;

    int n_tests = 0;
    int n_fail  = 0;
    int n_out   = 0;
    int ready_mode = 0;  // 0: always ready, 1: never ready, 2: random
    logic [2*W:0] sb_q[$];
    logic [2*W:0] sb_e;

    cdm_pipe_param #(.WIDTH(W), .K_LO(K_LO), .K_HI(K_HI)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_mode  (in_mode),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_r    (out_r),
        .out_mode (out_mode)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: per column, count the set A[i]&Bh[j] terms; below k keep count mod 2.
    function automatic longint unsigned half_model(input logic [W-1:0] a,
                                                   input logic [H-1:0] bh, input int k);
        longint unsigned s;
        int cnt;
        int j;
        s = 0;
        for (int c = 0; c < int'(W + H - 1); c++) begin
            cnt = 0;
            for (int i = 0; i < int'(W); i++) begin
                j = c - i;
                if (j >= 0 && j < int'(H) && a[i] && bh[j]) cnt++;
            end
            if (c < k) s += longint'(cnt % 2) << c;
            else       s += longint'(cnt) << c;
        end
        return s;
    endfunction

    function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic m);
        longint unsigned plo, phi;
        logic [H-1:0] bl, bh;
        bl  = b[H-1:0];
        bh  = b[W-1:H];
        plo = half_model(a, bl, m ? int'(K_LO) : 0);
        phi = half_model(a, bh, m ? int'(K_HI) : 0);
        return (2*W)'(plo + (phi << H));
    endfunction

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            default: return W'($urandom);
        endcase
    endfunction

    // Scoreboard: record accepted beats, compare every delivered result in order.
    always @(negedge clk) begin
        if (rst_n) begin
            if (in_valid && in_ready) sb_q.push_back({in_mode, model(in_a, in_b, in_mode)});
            if (out_valid && out_ready) begin
                n_out++;
                if (sb_q.size() == 0) begin
                    check("unexpected_out", 1, 0);
                end else begin
                    sb_e = sb_q.pop_front();
                    check("sb_r", longint'(out_r), longint'(sb_e[2*W-1:0]));
                    check("sb_mode", longint'(out_mode), longint'(sb_e[2*W]));
                end
            end
        end
    end

    // Consumer ready pattern.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'b0;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic m);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_mode  = m;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                @(posedge clk);
                #1;
                break;
            end
        end
        in_valid = 1'b0;
        if (!ok) check("send_timeout", 0, 1);
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 200; t++) begin
            @(posedge clk);
            #1;
            if (sb_q.size() == 0 && !out_valid) break;
        end
        check("drain_left", sb_q.size(), 0);
        check("drain_valid", longint'(out_valid), 0);
    endtask

    logic [W-1:0]   dir_a [8] = '{8'd3, 8'd3, 8'd3, 8'd3, 8'hF0, 8'hF0, 8'hFF, 8'hFF};
    logic [W-1:0]   dir_b [8] = '{8'd3, 8'd3, 8'h30, 8'h30, 8'h0F, 8'h0F, 8'h01, 8'h01};
    logic           dir_m [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [2*W-1:0] dir_r [8] = '{16'd5, 16'd9, 16'd80, 16'd144, 16'd2384, 16'd3600,
                                  16'd255, 16'd255};

    initial begin
        int acc_cnt;
        int base_out;
        logic acc;
        logic [2*W-1:0] held_r;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_mode   = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_out_r", longint'(out_r), 0);
        check("rst_out_mode", longint'(out_mode), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", longint'(in_ready), 1);

        // Directed vectors with latency check.
        for (int v = 0; v < 8; v++) begin
            send(dir_a[v], dir_b[v], dir_m[v]);
            check("lat_edge0", longint'(out_valid), 0);
            @(posedge clk);
            #1;
            check("lat_edge1", longint'(out_valid), 0);
            @(posedge clk);
            #1;
            check("lat_edge2_valid", longint'(out_valid), 1);
            check("dir_r", longint'(out_r), longint'(dir_r[v]));
            check("dir_mode", longint'(out_mode), longint'(dir_m[v]));
            @(posedge clk);
            #1;
        end
        wait_drain();

        // Back-to-back beats, one result per cycle.
        base_out = n_out;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_a     = pick_operand();
            in_b     = pick_operand();
            in_mode  = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("b2b_in_ready", longint'(in_ready), 1);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("b2b_throughput", n_out - base_out, 10);
        wait_drain();

        // Stall: exactly three beats fit, output held stable.
        ready_mode = 1;
        @(posedge clk);
        #2;
        acc_cnt = 0;
        in_valid = 1'b1;
        in_a = pick_operand();
        in_b = pick_operand();
        in_mode = 1'($urandom_range(0, 1));
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                acc_cnt++;
                in_a = pick_operand();
                in_b = pick_operand();
                in_mode = 1'($urandom_range(0, 1));
            end
        end
        check("stall_accepts", acc_cnt, 3);
        check("stall_in_ready", longint'(in_ready), 0);
        check("stall_out_valid", longint'(out_valid), 1);
        held_r = out_r;
        repeat (2) @(posedge clk);
        #1;
        check("stall_hold_r", longint'(out_r), longint'(held_r));
        in_valid = 1'b0;
        ready_mode = 0;
        wait_drain();

        // Sparse input with a toggling consumer.
        ready_mode = 2;
        for (int i = 0; i < 30; i++) begin
            send(pick_operand(), pick_operand(), 1'($urandom_range(0, 1)));
            repeat (2) @(posedge clk);
            #1;
        end
        ready_mode = 0;
        wait_drain();

        // Random stream.
        ready_mode = 2;
        for (int i = 0; i < 400; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_a     = pick_operand();
            in_b     = pick_operand();
            in_mode  = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        ready_mode = 0;
        wait_drain();

        // Reset with three beats in flight.
        ready_mode = 1;
        @(posedge clk);
        #2;
        for (int i = 0; i < 3; i++) send(pick_operand() | 8'h01, pick_operand() | 8'h01, 1'b0);
        check("pre_rst_valid", longint'(out_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", longint'(out_valid), 0);
        check("mid_rst_r", longint'(out_r), 0);
        check("mid_rst_mode", longint'(out_mode), 0);
        sb_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ready_mode = 0;
        check("post_rst_in_ready", longint'(in_ready), 1);
        base_out = n_out;
        repeat (10) @(posedge clk);
        #1;
        check("post_rst_no_stale", n_out - base_out, 0);
        check("post_rst_valid", longint'(out_valid), 0);

        // Pipe still works after reset.
        send(8'd3, 8'd3, 1'b1);
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
